// File: rtl/fft_mag_writer.sv
// fft_mag_writer: captures one frame of FFT bins, squares and sums each bin's
// real/imag parts in a two-stage pipeline, and writes the magnitude-squared
// into RAM at the bin's index. A complete frame is held (fftdone) until the
// peak detector signals that it has finished reading it.
module fft_mag_writer #(
  parameter int NBINS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sink_valid,
  input  logic               sink_sop,
  input  logic               sink_eop,
  input  logic signed [13:0] sink_real,
  input  logic signed [13:0] sink_imag,
  output logic               sink_ready,
  input  logic               detectdone,
  output logic [10:0]        ramwaddr,
  output logic [27:0]        ramdata,
  output logic               ramwren,
  output logic               fftdone,
  output logic               frameerr
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_CAPTURE = 2'd1;
  localparam logic [1:0]  ST_HOLD    = 2'd2;
  localparam logic [10:0] LAST_IDX   = 11'(NBINS - 1);

  // Control state
  logic [1:0]  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;      // index the next non-sop bin will take
  logic        drain_q, drain_d;  // final bin accepted, waiting for its write
  logic        err_q, err_d;

  // Pipeline stage 1: squares plus tag
  logic        s1_vld_q, s1_vld_d;
  logic        s1_last_q, s1_last_d;
  logic [10:0] s1_addr_q, s1_addr_d;
  logic [27:0] re_sq_q, re_sq_d;
  logic [27:0] im_sq_q, im_sq_d;

  // Pipeline stage 2: RAM write port
  logic        wr_q, wr_d;
  logic        s2_last_q, s2_last_d;
  logic [10:0] waddr_q, waddr_d;
  logic [27:0] wdata_q, wdata_d;

  // Handshake helpers
  logic               ready_state;
  logic               xfer;
  logic               accept;
  logic [10:0]        idx;
  logic signed [27:0] re_ext;
  logic signed [27:0] im_ext;

  assign ready_state = (state_q == ST_IDLE) || ((state_q == ST_CAPTURE) && !drain_q);
  assign sink_ready  = ready_state && !reset;
  assign xfer        = sink_valid && sink_ready;
  // In IDLE only a sop sample starts a frame; everything else is dropped.
  assign accept      = xfer && ((state_q == ST_CAPTURE) || sink_sop);
  assign idx         = sink_sop ? 11'd0 : cnt_q;
  assign re_ext      = {{14{sink_real[13]}}, sink_real};
  assign im_ext      = {{14{sink_imag[13]}}, sink_imag};

  // Frame FSM: start, count, error detection, drain and hold
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    err_d     = err_q;
    s1_last_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer && sink_sop) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (drain_q) begin
          // Final write is on the RAM port this cycle; hold from the next one.
          if (s2_last_q) begin
            state_d = ST_HOLD;
            drain_d = 1'b0;
          end
        end else if (xfer && sink_sop) begin
          err_d = 1'b1;  // restart with this sample as bin 0
        end
      end
      ST_HOLD: begin
        if (detectdone) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      if (sink_eop && (idx == LAST_IDX)) begin
        s1_last_d = 1'b1;
        drain_d   = 1'b1;
        state_d   = ST_CAPTURE;
      end else if (sink_eop || (idx == LAST_IDX)) begin
        // Early eop or missing eop: bin is still written, frame is dropped.
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        cnt_d   = idx + 11'd1;
        state_d = ST_CAPTURE;
      end
    end
  end

  // Magnitude pipeline next-state: squares, then sum; data held when idle
  always_comb begin
    s1_vld_d  = accept;
    s1_addr_d = accept ? idx : s1_addr_q;
    re_sq_d   = accept ? 28'(re_ext * re_ext) : re_sq_q;
    im_sq_d   = accept ? 28'(im_ext * im_ext) : im_sq_q;
    wr_d      = s1_vld_q;
    s2_last_d = s1_vld_q && s1_last_q;
    waddr_d   = s1_vld_q ? s1_addr_q : waddr_q;
    // Max is 2^27 for (-8192,-8192), so the 28-bit sum cannot overflow.
    wdata_d   = s1_vld_q ? (re_sq_q + im_sq_q) : wdata_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 11'd0;
      drain_q   <= 1'b0;
      err_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_addr_q <= 11'd0;
      re_sq_q   <= 28'd0;
      im_sq_q   <= 28'd0;
      wr_q      <= 1'b0;
      s2_last_q <= 1'b0;
      waddr_q   <= 11'd0;
      wdata_q   <= 28'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s1_addr_q <= s1_addr_d;
      re_sq_q   <= re_sq_d;
      im_sq_q   <= im_sq_d;
      wr_q      <= wr_d;
      s2_last_q <= s2_last_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign ramwren  = wr_q;
  assign ramwaddr = waddr_q;
  assign ramdata  = wdata_q;
  assign fftdone  = (state_q == ST_HOLD);
  assign frameerr = err_q;

endmodule

// File: tb/tb_fft_mag_writer.sv
// Directed bench for fft_mag_writer with a write scoreboard: every accepted
// bin pushes its expected address/data/write cycle; the RAM write monitor pops.
module tb_fft_mag_writer;
  localparam int NB = 1024;

  logic               clk = 1'b0;
  logic               reset;
  logic               sink_valid, sink_sop, sink_eop;
  logic signed [13:0] sink_real, sink_imag;
  logic               sink_ready;
  logic               detectdone;
  logic [10:0]        ramwaddr;
  logic [27:0]        ramdata;
  logic               ramwren, fftdone, frameerr;

  typedef struct {
    logic [10:0] addr;
    logic [27:0] data;
    int          cyc;
  } exp_t;

  exp_t               sb[$];
  logic signed [13:0] re_tab[NB];
  logic signed [13:0] im_tab[NB];
  int                 errors = 0;
  int                 checks = 0;
  int                 cyc = 0;
  int                 wr_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_mag_writer #(.NBINS(NB)) dut (
    .clk(clk), .reset(reset),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_ready(sink_ready),
    .detectdone(detectdone),
    .ramwaddr(ramwaddr), .ramdata(ramdata), .ramwren(ramwren),
    .fftdone(fftdone), .frameerr(frameerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [27:0] magsq(input logic signed [13:0] r, input logic signed [13:0] i);
    int rr, ii;
    rr = r;
    ii = i;
    return 28'(rr * rr + ii * ii);
  endfunction

  // RAM write monitor: each write must match the oldest outstanding bin
  always @(negedge clk) begin
    exp_t e;
    if (ramwren === 1'b1) begin
      wr_count++;
      chk("write_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(ramwaddr), 32'(e.addr));
        chk("wr_data", 32'(ramdata), 32'(e.data));
        chk("wr_latency", 32'(cyc), 32'(e.cyc + 2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one cycle; push its expected write if accepted
  task automatic send(input bit sop, input bit eop, input logic signed [13:0] re,
                      input logic signed [13:0] im, input bit acc, input logic [10:0] addr);
    exp_t e;
    int   p;
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_real  = re;
    sink_imag  = im;
    p = cyc;
    tick();
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    if (acc) begin
      e.addr = addr;
      e.data = magsq(re, im);
      e.cyc  = p;
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input int last, input bit use_eop, input bit bubbles);
    for (int b = 0; b <= last; b++) begin
      if (bubbles) repeat ($urandom_range(0, 2)) tick();
      send(b == 0, use_eop && (b == last), re_tab[b], im_tab[b], 1'b1, 11'(b));
    end
  endtask

  task automatic fill_random();
    for (int b = 0; b < NB; b++) begin
      re_tab[b] = 14'($urandom_range(0, 16383));
      im_tab[b] = 14'($urandom_range(0, 16383));
    end
  endtask

  // After the last bin: no done yet, final write, then done one cycle later
  task automatic frame_end_checks(input string tag);
    @(negedge clk);
    chk({tag, "_done_early"}, 32'(fftdone), 32'd0);
    @(negedge clk);
    chk({tag, "_last_wren"}, 32'(ramwren), 32'd1);
    chk({tag, "_last_addr"}, 32'(ramwaddr), 32'd1023);
    chk({tag, "_done_at_write"}, 32'(fftdone), 32'd0);
  endtask

  initial begin
    reset = 1'b1; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_real = '0; sink_imag = '0; detectdone = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(sink_ready), 32'd0);
    chk("rst_fftdone", 32'(fftdone), 32'd0);
    chk("rst_wren", 32'(ramwren), 32'd0);
    chk("rst_waddr", 32'(ramwaddr), 32'd0);
    chk("rst_wdata", 32'(ramdata), 32'd0);
    chk("rst_frameerr", 32'(frameerr), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(sink_ready), 32'd1);
    tick();

    // Frame A: single tone at bin 204, back to back
    for (int b = 0; b < NB; b++) begin re_tab[b] = '0; im_tab[b] = '0; end
    re_tab[204] = 14'sh0FF;
    chk("tone_model", 32'(magsq(re_tab[204], im_tab[204])), 32'h000FE01);
    send_frame(1023, 1'b1, 1'b0);
    frame_end_checks("A");
    @(negedge clk);
    chk("A_done_rise", 32'(fftdone), 32'd1);
    chk("A_hold_ready", 32'(sink_ready), 32'd0);
    chk("A_writes", 32'(wr_count), 32'd1024);

    // HOLD: offered sop samples are refused and never written
    tick();
    sink_valid = 1'b1; sink_sop = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_ready", 32'(sink_ready), 32'd0);
      chk("hold_done", 32'(fftdone), 32'd1);
      tick();
    end
    sink_valid = 1'b0; sink_sop = 1'b0;
    detectdone = 1'b1;
    tick();
    detectdone = 1'b0;
    @(negedge clk);
    chk("dd_clears_done", 32'(fftdone), 32'd0);
    chk("dd_ready", 32'(sink_ready), 32'd1);
    chk("hold_no_writes", 32'(wr_count), 32'd1024);

    // detectdone in IDLE has no effect
    tick();
    detectdone = 1'b1;
    tick();
    detectdone = 1'b0;
    @(negedge clk);
    chk("idle_dd_done", 32'(fftdone), 32'd0);
    chk("idle_dd_ready", 32'(sink_ready), 32'd1);
    tick();

    // Frame B: random data with bubbles, extreme value at bin 5
    fill_random();
    re_tab[5] = -14'sd8192;
    im_tab[5] = -14'sd8192;
    chk("extreme_model", 32'(magsq(re_tab[5], im_tab[5])), 32'h8000000);
    send_frame(1023, 1'b1, 1'b1);
    frame_end_checks("B");
    // detectdone on the first HOLD cycle: HOLD lasts exactly one cycle
    tick();
    detectdone = 1'b1;
    @(negedge clk);
    chk("B_done_rise", 32'(fftdone), 32'd1);
    tick();
    detectdone = 1'b0;
    @(negedge clk);
    chk("B_one_cycle_hold", 32'(fftdone), 32'd0);
    chk("B_ready", 32'(sink_ready), 32'd1);
    chk("B_frameerr", 32'(frameerr), 32'd0);
    chk("B_writes", 32'(wr_count), 32'd2048);
    tick();

    // Early eop at bin 500
    fill_random();
    send_frame(500, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("early_frameerr", 32'(frameerr), 32'd1);
    chk("early_fftdone", 32'(fftdone), 32'd0);
    chk("early_idle_ready", 32'(sink_ready), 32'd1);
    tick();
    send(1'b0, 1'b0, 14'sd100, 14'sd100, 1'b0, 11'd0);  // no sop in IDLE: dropped
    repeat (3) @(negedge clk);
    chk("early_writes", 32'(wr_count), 32'd2549);
    tick();
    fill_random();
    send_frame(1023, 1'b1, 1'b0);
    frame_end_checks("C");
    @(negedge clk);
    chk("C_done_rise", 32'(fftdone), 32'd1);
    chk("C_err_sticky", 32'(frameerr), 32'd1);
    tick();
    detectdone = 1'b1;
    tick();
    detectdone = 1'b0;

    // Reset at bin 300: bin 298 is already on the write port, 299/300 are lost
    fill_random();
    send_frame(299, 1'b0, 1'b0);
    reset = 1'b1;
    sink_valid = 1'b1; sink_real = re_tab[300]; sink_imag = im_tab[300];
    @(negedge clk);
    chk("mid_rst_ready", 32'(sink_ready), 32'd0);
    tick();
    sink_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_wren", 32'(ramwren), 32'd0);
    chk("mid_rst_done", 32'(fftdone), 32'd0);
    chk("mid_rst_err_clr", 32'(frameerr), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(sink_ready), 32'd1);
    chk("post_rst_dropped", 32'(sb.size()), 32'd1);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("post_rst_quiet", 32'(ramwren), 32'd0);
    tick();
    fill_random();
    send_frame(1023, 1'b1, 1'b1);
    frame_end_checks("D");
    @(negedge clk);
    chk("D_done_rise", 32'(fftdone), 32'd1);
    chk("D_frameerr", 32'(frameerr), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
